// File: rtl/aes_pkg.sv
// aes_pkg
// Shared AES constants and helpers for the key-schedule engine and the round
// datapath: key/round sizing, the forward S-box, the round-constant table and
// the key-schedule state encoding.
//   aes_sbox(b)     : forward S-box lookup, 8-bit in / 8-bit out
//   aes_rcon(round) : round constant for rounds 1..10, 0 for any other index
package aes_pkg;

  localparam int AES_KEY_W = 128;
  localparam int AES_NR    = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ks_state_e;

  // Row r holds S-box outputs for inputs 16*r .. 16*r+15; element 0 is the
  // leftmost byte of the first row.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i <= AES_NR; i++) begin
      if (round == 4'(i)) r = RCON[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word
// Combinational SubWord: four independent S-box lookups on a 32-bit word.
// Byte order is preserved (word_i[31:24] maps to word_o[31:24]).
//   word_i : 32-bit input word
//   word_o : 32-bit substituted word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = aes_sbox(word_i[8*b +: 8]);
  end

endmodule

// File: rtl/aes128_key_expand.sv
// aes128_key_expand
// Iterative AES-128 key schedule. Accepts one cipher key and streams round
// keys 0..10 over a valid/ready interface, one per cycle when not stalled.
//   clk, rst_n         : clock, asynchronous active-low reset
//   key_valid/key_ready: cipher key handshake (ready only while idle)
//   key_in             : cipher key, word w0 in [127:96]
//   rk_valid/rk_ready  : round key handshake
//   rk_idx, rk_out     : round index 0..10 and its round key
//   busy               : a schedule is in progress
//   done               : one-cycle pulse after round key 10 is taken
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a cipher key; key_ready high
// ST_EMIT | presenting round key idx_q; advance on each rk handshake
module aes128_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [3:0]           rk_idx,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic                 busy,
  output logic                 done
);

  if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
    $error("aes128_key_expand supports only NUM_ROUNDS == 10");
  end

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_e            state_q;
  logic [AES_KEY_W-1:0] key_q;
  logic [AES_KEY_W-1:0] key_d;
  logic [3:0]           idx_q;
  logic                 done_q;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, temp_w;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word_i (rot_w),
    .word_o (sub_w)
  );

  // At idx 10 the rcon lookup falls out of range and returns 0; key_d is not
  // loaded in that case, so the value is irrelevant.
  assign temp_w = sub_w ^ {aes_rcon(idx_q + 4'd1), 24'h000000};

  assign n0    = w0 ^ temp_w;
  assign n1    = w1 ^ n0;
  assign n2    = w2 ^ n1;
  assign n3    = w3 ^ n2;
  assign key_d = {n0, n1, n2, n3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            key_q   <= key_in;
            idx_q   <= 4'd0;
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (rk_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              key_q <= key_d;
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign key_ready = (state_q == ST_IDLE);
  assign rk_valid  = (state_q == ST_EMIT);
  assign busy      = (state_q == ST_EMIT);
  assign rk_out    = key_q;
  assign rk_idx    = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes128_key_expand.sv
module tb_aes128_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox_m [0:255];
  logic [7:0]   rcon_m [1:10];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  always #5 clk = ~clk;

  aes128_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic init_model();
    logic [7:0] inv, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      rcon_m[i] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Standard word-oriented expansion into 44 words, grouped into 11 round keys.
  task automatic set_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word_m({t[23:0], t[31:24]}) ^ {rcon_m[i/4], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_key(input logic [127:0] k);
    int c;
    c = 0;
    while (key_ready !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL drive_key: key_ready=%b, want 1", key_ready);
    end
    key_valid = 1'b1;
    key_in    = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Pull round keys 0..stop_at-1 with optional random stalls, checking each
  // against the model. Optionally pulses a foreign key during round inject_at.
  task automatic consume(input string tag, input int max_stall, input int inject_at, input int stop_at);
    int stall;
    for (int i = 0; i < stop_at; i++) begin
      stall = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      if (i == inject_at) begin
        key_valid = 1'b1;
        key_in    = rand128();
      end else if (inject_at >= 0 && i == inject_at + 1) begin
        key_valid = 1'b0;
      end
      for (int s = 0; s <= stall; s++) begin
        n_cmp++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== exp_rk[i]) begin
          n_err++;
          $display("FAIL %s rk[%0d]: got valid=%b idx=%0d rk=%h, want valid=1 idx=%0d rk=%h",
                   tag, i, rk_valid, rk_idx, rk_out, i, exp_rk[i]);
        end
        n_cmp++;
        if (key_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL %s status[%0d]: got key_ready=%b busy=%b done=%b, want 0 1 0",
                   tag, i, key_ready, busy, done);
        end
        got_rk[i] = rk_out;
        rk_ready  = (s == stall);
        @(negedge clk);
      end
    end
    if (stop_at > 10) begin
      n_cmp++;
      if (done !== 1'b1 || key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s end: got done=%b key_ready=%b rk_valid=%b busy=%b, want 1 1 0 0",
                 tag, done, key_ready, rk_valid, busy);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (key_ready !== 1'b1) begin n_err++; $display("FAIL reset key_ready: got %b want 1", key_ready); end
    n_cmp++;
    if (rk_valid !== 1'b0) begin n_err++; $display("FAIL reset rk_valid: got %b want 0", rk_valid); end
    n_cmp++;
    if (rk_idx !== 4'd0) begin n_err++; $display("FAIL reset rk_idx: got %0d want 0", rk_idx); end
    n_cmp++;
    if (rk_out !== 128'h0) begin n_err++; $display("FAIL reset rk_out: got %h want 0", rk_out); end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset idle: got key_ready=%b rk_valid=%b want 1 0", key_ready, rk_valid);
    end
  endtask

  task automatic test_zero_key();
    set_model(128'h0);
    drive_key(128'h0);
    consume("zero", 0, -1, 11);
    n_cmp++;
    if (got_rk[1] !== 128'h62636363626363636263636362636363) begin
      n_err++; $display("FAIL zero rk1: got %h want 62636363626363636263636362636363", got_rk[1]);
    end
    n_cmp++;
    if (got_rk[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      n_err++; $display("FAIL zero rk10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", got_rk[10]);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL zero done_pulse: got %b want 0", done); end
  endtask

  task automatic test_fips();
    logic [127:0] k;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    set_model(k);
    drive_key(k);
    consume("fips", 0, -1, 11);
    n_cmp++;
    if (got_rk[0] !== k) begin n_err++; $display("FAIL fips rk0: got %h want %h", got_rk[0], k); end
    n_cmp++;
    if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      n_err++; $display("FAIL fips rk1: got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]);
    end
    n_cmp++;
    if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_err++; $display("FAIL fips rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
    end
  endtask

  task automatic test_stalls();
    logic [127:0] k;
    for (int n = 0; n < 3; n++) begin
      k = rand128();
      set_model(k);
      drive_key(k);
      consume("stall", 5, -1, 11);
    end
  endtask

  task automatic test_ignore_key();
    logic [127:0] k;
    k = rand128();
    set_model(k);
    drive_key(k);
    consume("ignore", 2, 3, 11);
    key_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    k = rand128();
    set_model(k);
    drive_key(k);
    consume("pre_reset", 0, -1, 5);
    n_cmp++;
    if (rk_idx !== 4'd5 || rk_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_reset at_idx: got idx=%0d valid=%b want 5 1", rk_idx, rk_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rk_idx !== 4'd0 || rk_out !== 128'h0) begin
      n_err++; $display("FAIL mid_reset data: got idx=%0d rk=%h want 0 0", rk_idx, rk_out);
    end
    n_cmp++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset ctrl: got key_ready=%b rk_valid=%b busy=%b done=%b want 1 0 0 0",
               key_ready, rk_valid, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    k = rand128();
    set_model(k);
    drive_key(k);
    consume("post_reset", 1, -1, 11);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1, k2;
    k1 = rand128();
    k2 = rand128();
    set_model(k1);
    drive_key(k1);
    // drive_key dropped key_valid; restore it immediately so it stays high
    // from the engine's point of view (it is ignored while emitting).
    key_valid = 1'b1;
    key_in    = k2;
    consume("b2b_first", 0, -1, 11);
    set_model(k2);
    @(negedge clk);
    key_valid = 1'b0;
    consume("b2b_second", 0, -1, 11);
  endtask

  initial begin
    init_model();
    test_reset();
    test_zero_key();
    test_fips();
    test_stalls();
    test_ignore_key();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_key_expand.md
# aes128_key_expand

Iterative AES-128 key-schedule engine. It sits directly upstream of the `aes1` round datapath and turns one 128-bit cipher key into the 11 round keys (round 0 to round 10). It produces one round key per cycle over a valid/ready stream. A downstream consumer, such as a round-key register file or an iterative round stage, pulls keys in order. Only one S-box word path is used (4 byte lookups), so area stays small compared with a fully unrolled schedule.

## Interface
- `NUM_ROUNDS`, default 10, number of round keys after round 0. Only 10 (AES-128) is supported; any other value is an elaboration error.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_valid` input 1: `key_in` is valid.
- `key_ready` output 1: engine can accept a key. High only in IDLE.
- `key_in` input 128: cipher key. Word w0 = `[127:96]`, w3 = `[31:0]`; byte 0 = `[127:120]`.
- `rk_valid` output 1: `rk_out` and `rk_idx` are valid.
- `rk_ready` input 1: consumer accepts the current round key.
- `rk_idx` output 4: round index of `rk_out`, 0 to 10.
- `rk_out` output 128: round key, same word/byte order as `key_in`.
- `busy` output 1: high from key acceptance until the last round key is accepted.
- `done` output 1: one-cycle pulse the cycle after round key 10 is accepted.

## Operation
- States are IDLE and EMIT.
- IDLE:
  - `key_ready`=1 and `rk_valid`=0.
  - When `key_valid` and `key_ready` are both high: load the key register with `key_in`, set idx to 0, go to EMIT.
- EMIT:
  - `rk_valid`=1, `rk_out`=key register, `rk_idx`=idx.
  - On handshake with idx<10: key register ← next(key register, rcon[idx+1]), and idx increments.
  - On handshake with idx=10: go to IDLE and pulse `done` on the next cycle.
- next(): temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0 ^ temp, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
- rcon for rounds 1 to 10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- All XOR is 8-bit GF(2) with no carries. idx never exceeds 10.
- Backpressure: while `rk_valid`=1 and `rk_ready`=0, `rk_out` and `rk_idx` hold stable.
- `key_valid` while not in IDLE is ignored (`key_ready`=0), and `key_in` is not sampled.
- Reset, including mid-sequence, returns to IDLE immediately; any partial schedule is discarded.
- Reset values: `key_ready`=1, `rk_valid`=0, `rk_idx`=0, `rk_out`=0, `busy`=0, `done`=0, key register=0.

## Timing
- Key accepted at edge t, so round key 0 is valid in cycle t+1.
- With `rk_ready` held high, round key i is valid in cycle t+1+i. Round key 10 is in cycle t+11, `done` in cycle t+12, and `key_ready` is high again in t+12.
- Round-key throughput is 1 per cycle. The next() logic is a single combinational stage (4 S-boxes plus XOR chain) feeding the key register.
- In the cycle round key 10 is accepted, `key_ready` is still 0. The earliest new key acceptance is cycle t+12.
- `busy` = (state==EMIT). `done` is registered.

## Structure
- Shared package `aes_pkg`:
  - The S-box table as a 256×8 constant function.
  - The rcon array (index 1 to 10).
  - The state enum (IDLE, EMIT).
  - Constants AES_KEY_W=128, AES_NR=10.
- Sub-module `aes_sub_word`: 32-bit combinational SubWord built from four S-box lookups. It is also reusable by the round datapath's SubBytes.

## Test plan
- Zero key `00000000000000000000000000000000`, `rk_ready`=1. Required: rk1=`62636363626363636263636362636363`, rk10=`b4ef5bcb3e92e21123e951cf6f8f188e`, and `done` exactly 12 cycles after acceptance.
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`. Required: rk0 equals the key, rk1=`a0fafe1788542cb123a339392a6c7605`, rk10=`d014f9a8c9ee2589e13f0cc8b6630ca6`.
- Random `rk_ready` stalls of 0 to 5 cycles. Required: `rk_out` and `rk_idx` stable during stalls, and the same 11 keys in order with no skipped or duplicated index.
- `key_valid` pulsed with a different key mid-sequence. Required: it is ignored, `key_ready`=0, and the current schedule is unchanged.
- `rst_n` asserted at idx=5. Required: outputs take their reset values asynchronously. After release, a new key restarts from rk_idx=0.
- Back-to-back keys with `key_valid` held high. Required: the second key is accepted in the cycle `done` pulses, and its rk0 follows one cycle later.
